hz_layer_ctrl: RTL
==================

# hz_layer_ctrl

Frame-synchronous animation controller for the 16×16 Hanzi text layer. It owns the layer's origin (org_x, org_y) and per-glyph enables, and sequences a reveal → bounce-scroll → blink-out animation on operator command. All changes are applied only on a frame tick so the layer never tears mid-frame. It sits between the VGA timing counters and the text layer, which draws glyphs 0/1/2 at org_x, org_x+32 and org_x+64 on row org_y.

## Interface
- X_INIT, 512: idle origin x.
- Y_INIT, 96: idle origin y (constant, no vertical motion).
- X_MIN, 0: left scroll bound for org_x.
- X_MAX, 544: right scroll bound for org_x (640−96).
- STEP, 2: pixels moved per scroll step.
- FRAME_Y, 480: y_pos value that marks the frame tick.
- BLINK_TOGGLES, 6: char_en toggles in BLINK. Must be even.

- clk  in  1  pixel clock
- rst_n  in  1  synchronous reset, active-low
- x_pos  in  10  current pixel column from timing generator
- y_pos  in  9  current pixel row from timing generator
- start  in  1  one-cycle request to begin animation
- stop  in  1  one-cycle request to end animation
- speed  in  4  frames per step minus 1; latched when start is accepted
- org_x  out  10  layer origin x
- org_y  out  9  layer origin y (always Y_INIT)
- char_en  out  3  per-glyph enable; bit i gates glyph i
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on BLINK→IDLE

## Operation
- Frame tick: a one-cycle internal pulse, registered, in the cycle after (x_pos==0 && y_pos==FRAME_Y) is sampled. The pulse fires only if the previous cycle did not also match, so a stalled counter yields one tick.
- Step: on each tick, frame_cnt increments. When frame_cnt==speed_q, frame_cnt returns to 0 and a step is issued. speed_q=0 steps on every tick.
- start and stop set sticky pending flags in any cycle. The flags are consumed only on a tick. If both are pending, stop wins and both clear.
- IDLE: org=(X_INIT,Y_INIT), char_en=111, dir=0, busy=0.
  - Pending start on a tick → REVEAL: char_en=000, frame_cnt=0, speed_q=speed.
  - Pending stop in IDLE is cleared and has no effect.
- REVEAL: each step shifts in a 1 (000→001→011→111). The step that produces 111 also enters SCROLL with frame_cnt=0. Origin is held.
- SCROLL: each step moves org_x.
  - Arithmetic is 11-bit to avoid wrap.
  - dir=0: if org_x+STEP ≥ X_MAX, set org_x=X_MAX and dir=1; else org_x+=STEP.
  - dir=1: if org_x < X_MIN+STEP, set org_x=X_MIN and dir=0; else org_x−=STEP.
- BLINK: entered when stop is pending on a tick from REVEAL or SCROLL.
  - On entry: char_en=111, toggle count=0, org_x frozen.
  - Each step inverts char_en. After BLINK_TOGGLES toggles, the next tick enters IDLE, restores the idle origin, sets char_en=111 and pulses done.
- Start pending while busy is cleared and ignored.

## Timing
- Reset values: org_x=X_INIT, org_y=Y_INIT, char_en=111, busy=0, done=0, dir=0, frame_cnt=0, pending flags=0, state=IDLE.
- A reset mid-animation returns all of the above on the next clk edge, with no done pulse.
- All outputs are registered. They change only in the cycle after the tick pulse, i.e. 2 clk after (0,FRAME_Y) is sampled, and are stable for the rest of the frame.
- busy rises with the IDLE→REVEAL update and falls with the BLINK→IDLE update. done is high for exactly that one cycle.
- A start or stop arriving in the same cycle as the tick pulse is consumed by that tick.

## Test plan
- Reset, drive 3 frames with no commands → org=(512,96), char_en=111, busy=0 throughout, done never high.
- start with speed=0, then ticks T1..T5:
  - T1: char_en=000, busy=1.
  - T2: 001. T3: 011.
  - T4: 111 and state SCROLL.
  - T5: org_x=514.
- SCROLL, speed=0, from org_x=512 → 544 after 16 steps; the 17th step gives 542. Force org_x near 0 with dir=1 → clamps at 0, then 2.
- stop during SCROLL at org_x=530, speed=0:
  - 6 ticks: char_en alternates 000/111, org_x stays 530.
  - 7th tick: IDLE, org_x=512, done pulses for 1 cycle, busy=0.
- start and stop asserted in the same cycle in IDLE → no state change on the next tick. speed=3 → steps only on every 4th tick (reveal reaches 111 after 13 ticks).
- Hold rst_n low for 1 cycle mid-BLINK → next cycle all reset values, done stays 0. Hold x_pos=0, y_pos=480 for 5 cycles → exactly one tick.

Source files
------------

// File: rtl/hz_layer_ctrl.sv
// rtl/hz_layer_ctrl.sv - frame-synchronous reveal/bounce-scroll/blink animation controller for the Hanzi text layer
module hz_layer_ctrl #(
  parameter int X_INIT        = 512,
  parameter int Y_INIT        = 96,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 544,
  parameter int STEP          = 2,
  parameter int FRAME_Y       = 480,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_pos,
  input  logic [8:0] y_pos,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] speed,
  output logic [9:0] org_x,
  output logic [8:0] org_y,
  output logic [2:0] char_en,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(BLINK_TOGGLES + 1);
  localparam logic [9:0]    X_INIT_V = 10'(X_INIT);
  localparam logic [9:0]    X_MIN_V  = 10'(X_MIN);
  localparam logic [9:0]    X_MAX_V  = 10'(X_MAX);
  localparam logic [10:0]   X_MAX_W  = 11'(X_MAX);
  localparam logic [10:0]   X_LOW_W  = 11'(X_MIN + STEP);
  localparam logic [10:0]   STEP_W   = 11'(STEP);
  localparam logic [9:0]    STEP_V   = 10'(STEP);
  localparam logic [8:0]    FRAME_Y_V = 9'(FRAME_Y);
  localparam logic [TW-1:0] TOG_END  = TW'(BLINK_TOGGLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    SCROLL = 2'd2,
    BLINK  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          match_now, match_prev, tick;
  logic          start_p, stop_p, start_eff, stop_eff;
  logic [3:0]    frame_cnt, frame_cnt_n;
  logic [3:0]    speed_q, speed_q_n;
  logic          step;
  logic          dir, dir_n;
  logic [TW-1:0] tog, tog_n;
  logic [9:0]    org_x_n;
  logic [2:0]    char_en_n;
  logic          busy_n, done_n;
  logic [10:0]   x_up;

  assign org_y = 9'(Y_INIT);

  // A counter stalled on the tick position must still produce a single tick.
  assign match_now = (x_pos == 10'd0) && (y_pos == FRAME_Y_V);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_prev <= 1'b0;
      tick       <= 1'b0;
    end else begin
      match_prev <= match_now;
      tick       <= match_now & ~match_prev;
    end
  end

  // Requests landing in the tick cycle itself are folded into that tick.
  assign start_eff = start_p | start;
  assign stop_eff  = stop_p | stop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_p <= 1'b0;
      stop_p  <= 1'b0;
    end else if (tick) begin
      start_p <= 1'b0;
      stop_p  <= 1'b0;
    end else begin
      start_p <= start_p | start;
      stop_p  <= stop_p | stop;
    end
  end

  assign step = tick && (frame_cnt == speed_q);
  assign x_up = {1'b0, org_x} + STEP_W;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      org_x     <= X_INIT_V;
      char_en   <= 3'b111;
      dir       <= 1'b0;
      frame_cnt <= 4'd0;
      speed_q   <= 4'd0;
      tog       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      org_x     <= org_x_n;
      char_en   <= char_en_n;
      dir       <= dir_n;
      frame_cnt <= frame_cnt_n;
      speed_q   <= speed_q_n;
      tog       <= tog_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    org_x_n     = org_x;
    char_en_n   = char_en;
    dir_n       = dir;
    speed_q_n   = speed_q;
    tog_n       = tog;
    done_n      = 1'b0;
    frame_cnt_n = frame_cnt;
    if (tick) begin
      frame_cnt_n = step ? 4'd0 : frame_cnt + 4'd1;
    end

    case (state)
      IDLE: begin
        org_x_n     = X_INIT_V;
        char_en_n   = 3'b111;
        dir_n       = 1'b0;
        frame_cnt_n = 4'd0;
        if (tick && start_eff && !stop_eff) begin
          state_n   = REVEAL;
          char_en_n = 3'b000;
          speed_q_n = speed;
        end
      end

      REVEAL: begin
        if (tick && stop_eff) begin
          state_n     = BLINK;
          char_en_n   = 3'b111;
          tog_n       = '0;
          frame_cnt_n = 4'd0;
        end else if (step) begin
          char_en_n = {char_en[1:0], 1'b1};
          if (char_en[1]) begin
            state_n = SCROLL;
          end
        end
      end

      SCROLL: begin
        if (tick && stop_eff) begin
          state_n     = BLINK;
          char_en_n   = 3'b111;
          tog_n       = '0;
          frame_cnt_n = 4'd0;
        end else if (step) begin
          if (!dir) begin
            if (x_up >= X_MAX_W) begin
              org_x_n = X_MAX_V;
              dir_n   = 1'b1;
            end else begin
              org_x_n = x_up[9:0];
            end
          end else begin
            if ({1'b0, org_x} < X_LOW_W) begin
              org_x_n = X_MIN_V;
              dir_n   = 1'b0;
            end else begin
              org_x_n = org_x - STEP_V;
            end
          end
        end
      end

      BLINK: begin
        // The exit waits for a full tick after the last toggle so the final lit frame is shown.
        if (tick && (tog == TOG_END)) begin
          state_n     = IDLE;
          org_x_n     = X_INIT_V;
          char_en_n   = 3'b111;
          dir_n       = 1'b0;
          frame_cnt_n = 4'd0;
          done_n      = 1'b1;
        end else if (step && (tog != TOG_END)) begin
          char_en_n = ~char_en;
          tog_n     = tog + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
